// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation request in, status and results out.
// The master drives requests; the ALU sits on the slave side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result_hi;
    logic             Zero;
    logic             Overflow;

    modport master (
        output start, ALUctl, a, b,
        input  busy, done, Result, Result_hi, Zero, Overflow
    );

    modport slave (
        input  start, ALUctl, a, b,
        output busy, done, Result, Result_hi, Zero, Overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus a WIDTH-cycle shift-add unsigned multiply.
// state | meaning
// IDLE  | waiting for start; results from the last op are held
// MUL   | one shift-add iteration per edge, busy=1
// DONE  | done=1 for this cycle; start is ignored
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   dif;
    logic               ovf_add;
    logic               ovf_sub;
    logic [WIDTH-1:0]   res_c;
    logic               ovf_c;
    logic [WIDTH:0]     acc;
    logic [2*WIDTH-1:0] prod_nxt;

    always_comb begin
        sum     = bus.a + bus.b;
        dif     = bus.a + ~bus.b + WIDTH'(1);
        ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
        res_c   = '0;
        ovf_c   = 1'b0;
        case (bus.ALUctl)
            OP_AND: res_c = bus.a & bus.b;
            OP_OR:  res_c = bus.a | bus.b;
            OP_ADD: begin
                res_c = sum;
                ovf_c = ovf_add;
            end
            OP_SUB: begin
                res_c = dif;
                ovf_c = ovf_sub;
            end
            // sign XOR overflow keeps SLT correct when a-b wraps
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ ovf_sub};
            OP_NOR: res_c = ~(bus.a | bus.b);
            default: begin
                res_c = '0;
                ovf_c = 1'b0;
            end
        endcase
    end

    // Add the multiplicand into the upper half, then shift the whole product right.
    always_comb begin
        acc      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (op_b[0] ? {1'b0, op_a} : '0);
        prod_nxt = {acc, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            prod          <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.Result    <= '0;
            bus.Result_hi <= '0;
            bus.Zero      <= 1'b0;
            bus.Overflow  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.ALUctl == OP_MULU) begin
                            op_a     <= bus.a;
                            op_b     <= bus.b;
                            prod     <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= MUL;
                        end else begin
                            bus.Result    <= res_c;
                            bus.Result_hi <= '0;
                            bus.Zero      <= (res_c == '0);
                            bus.Overflow  <= ovf_c;
                            bus.done      <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                MUL: begin
                    prod <= prod_nxt;
                    op_b <= op_b >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        bus.Result    <= prod_nxt[WIDTH-1:0];
                        bus.Result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
                        bus.Zero      <= (prod_nxt == '0);
                        bus.Overflow  <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 SHALL have port: ALUctl  input  4  operation select, sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A, sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B, sampled with start.
REQ-008 SHALL have port: busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; Result, Result_hi, Zero and Overflow are valid from this cycle.
REQ-010 SHALL have port: Result  output  WIDTH  result, or low half of the product.
REQ-011 SHALL have port: Result_hi  output  WIDTH  high half of the product; 0 for all non-multiply ops.
REQ-012 SHALL have port: Zero  output  1  result-equals-zero flag.
REQ-013 SHALL have port: Overflow  output  1  signed overflow flag.

Function
REQ-014 SHALL decode ALUctl as follows: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a-b), 0111 SLT (signed), 1100 NOR, 1000 MULU (unsigned WIDTH x WIDTH -> 2*WIDTH); every other code is illegal.
REQ-015 SHALL implement a state machine with states IDLE, MUL and DONE.
REQ-016 SHALL move from IDLE to DONE on start=1 with a single-cycle op: results registered at the accepting edge, done=1 for the next cycle only.
REQ-017 SHALL move from IDLE to MUL on start=1 with MULU: operands loaded at the accepting edge, product cleared, busy=1 starting the next cycle.
REQ-018 SHALL, in MUL, perform one shift-add iteration per edge using an internal counter from 0 to WIDTH-1; at the WIDTH-th edge after acceptance it registers the product, moves to DONE with busy=0 and asserts done for one cycle.
REQ-019 SHALL transition DONE -> IDLE unconditionally after one cycle; a start seen in the DONE cycle is ignored.
REQ-020 SHALL ignore start while busy=1 or in DONE; operands and ALUctl captured at acceptance are unaffected by later input changes.
REQ-021 SHALL hold Result, Result_hi, Zero and Overflow from done until the next accepted op completes; they are not cleared in IDLE.
REQ-022 SHALL compute ADD and SUB modulo 2^WIDTH, with SUB as a + ~b + 1.
REQ-023 SHALL set Overflow for ADD/SUB when the operand signs (b inverted for SUB) match and the result sign differs; Overflow=0 for every other op.
REQ-024 SHALL compute SLT as Result = {0..., sign(a-b) XOR overflow(a-b)}, correct across the full signed range.
REQ-025 SHALL set Zero to (Result==0) for single-cycle ops and to (Result==0 AND Result_hi==0) for MULU.
REQ-026 SHALL treat an illegal ALUctl with 1-cycle latency, Result=0, Result_hi=0, Zero=1 and Overflow=0.

Reset
REQ-027 SHALL, on rst=1 (asynchronous, at any time including mid-MUL), force state=IDLE, busy=0, done=0, Result=0, Result_hi=0, Zero=0, Overflow=0, the iteration counter to 0 and the operand registers to 0.
REQ-028 SHALL abandon an in-flight multiply on reset with no done pulse; the first edge after rst deasserts may accept start.

Verification (WIDTH=8)
REQ-029 SHALL be verified with: ADD a=0x7F, b=0x01 -> next cycle done=1, Result=0x80, Overflow=1, Zero=0.
REQ-030 SHALL be verified with: SUB a=0x05, b=0x05 -> Result=0x00, Zero=1, Overflow=0; then SLT a=0x80, b=0x01 -> Result=0x01; then SLT a=0x01, b=0x80 -> Result=0x00.
REQ-031 SHALL be verified with: MULU a=0xFF, b=0xFF -> busy high 8 cycles, done on the 8th edge after acceptance, Result_hi=0xFE, Result=0x01, Zero=0.
REQ-032 SHALL be verified with: start with ALUctl=0010 pulsed during MULU busy -> ignored, multiply result unchanged, exactly one done pulse.
REQ-033 SHALL be verified with: rst pulsed at MUL iteration 4 -> all outputs 0 immediately with no done; then NOR a=0x0F, b=0xF0 -> Result=0x00, Zero=1.
REQ-034 SHALL be verified with: ALUctl=1111 -> done after 1 cycle, Result=0, Zero=1, Overflow=0.
